spi_flash_rdctrl: RTL



---
 rtl/spi_flash_rdctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/spi_flash_rdctrl.sv
// spi_flash_rdctrl: single-lane SPI mode-0 read controller for a serial NOR
// flash. Wakes the flash with 0xAB after reset, then serves 32-bit reads with
// the 0x03 command. Sequential reads reuse the still-open transaction, so
// the command and address phase is skipped.
module spi_flash_rdctrl #(
  parameter int CSB_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [23:0] addr,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_GAP,
    S_IDLE,
    S_CMD,
    S_DATA
  } state_t;

  // Last half-period index of each timed phase (counter starts at 0)
  localparam logic [5:0] PWRUP_LAST = 6'd15;
  localparam logic [5:0] XFER_LAST  = 6'd63;
  localparam logic [5:0] GAP_LAST   = 6'(CSB_HIGH_CYCLES - 1);

  state_t      state_q;
  logic [5:0]  cnt_q;        // half-period index within the current phase
  logic [31:0] sh_q;         // outgoing shifter, MSB drives flash_mosi
  logic [30:0] rx_q;         // incoming bits, MSB first
  logic [23:0] addr_q;       // aligned address of the transfer in flight
  logic [23:0] next_addr_q;  // address the open transaction will stream next
  logic        next_valid_q;
  logic        cold_pend_q;  // GAP must be followed by a fresh 0x03 command
  logic        csb_q;
  logic        sclk_q;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic [23:0] req_addr;
  logic [31:0] rx_word;

  // Word alignment, and the full 32-bit word including the bit on the wire
  assign req_addr = addr & 24'hFFFFFC;
  assign rx_word  = {rx_q, flash_miso};

  assign ready      = ready_q;
  assign rdata      = rdata_q;
  assign flash_csb  = csb_q;
  assign flash_clk  = sclk_q;
  assign flash_mosi = sh_q[31];

  // Controller FSM: all SPI pins and the host handshake are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_PWRUP;
      cnt_q        <= '0;
      sh_q         <= '0;
      rx_q         <= '0;
      addr_q       <= '0;
      next_addr_q  <= '0;
      next_valid_q <= 1'b0;
      cold_pend_q  <= 1'b0;
      csb_q        <= 1'b1;
      sclk_q       <= 1'b0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_PWRUP: begin
          if (csb_q) begin
            // First cycle out of reset: open the wake-up transaction
            csb_q  <= 1'b0;
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            sh_q   <= {8'hAB, 24'h000000};
          end else if (cnt_q == PWRUP_LAST) begin
            state_q     <= S_GAP;
            csb_q       <= 1'b1;
            sclk_q      <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            cold_pend_q <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 6'd1;
            sclk_q <= ~sclk_q;
            // Advance MOSI only as flash_clk falls
            if (sclk_q) sh_q <= {sh_q[30:0], 1'b0};
          end
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (cold_pend_q) begin
              state_q     <= S_CMD;
              csb_q       <= 1'b0;
              sh_q        <= {8'h03, addr_q};
              cold_pend_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end

        S_IDLE: begin
          // A request still asserted during the ready cycle belongs to the
          // transfer that just finished, so it is not taken again
          if (valid && !ready_q) begin
            addr_q <= req_addr;
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            if (csb_q) begin
              state_q <= S_CMD;
              csb_q   <= 1'b0;
              sh_q    <= {8'h03, req_addr};
            end else if (next_valid_q && (req_addr == next_addr_q)) begin
              state_q <= S_DATA;
              sh_q    <= '0;
            end else begin
              state_q     <= S_GAP;
              csb_q       <= 1'b1;
              cold_pend_q <= 1'b1;
              sh_q        <= '0;
            end
          end
        end

        S_CMD: begin
          if (cnt_q == XFER_LAST) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
            sh_q    <= '0;
          end else begin
            cnt_q  <= cnt_q + 6'd1;
            sclk_q <= ~sclk_q;
            if (sclk_q) sh_q <= {sh_q[30:0], 1'b0};
          end
        end

        S_DATA: begin
          // Sample MISO at the edge that ends each flash_clk-high cycle
          if (sclk_q) rx_q <= rx_word[30:0];
          if (cnt_q == XFER_LAST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sclk_q       <= 1'b0;
            ready_q      <= 1'b1;
            rdata_q      <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
            next_addr_q  <= addr_q + 24'd4;
            next_valid_q <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 6'd1;
            sclk_q <= ~sclk_q;
          end
        end

        default: begin
          state_q <= S_PWRUP;
          csb_q   <= 1'b1;
          sclk_q  <= 1'b0;
          sh_q    <= '0;
        end
      endcase
    end
  end

endmodule
